// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one BCD-to-binary converter between two requesters.
// Optional WAIT-state timeout enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         req0_i,
    input  logic [N-1:0] bcd0_i,
    output logic         ack0_o,
    output logic         done0_o,
    output logic [31:0]  result0_o,
    input  logic         req1_i,
    input  logic [N-1:0] bcd1_i,
    output logic         ack1_o,
    output logic         done1_o,
    output logic [31:0]  result1_o,
    output logic         busy_o,
    output logic         err_o,
    output logic         cv_start_o,
    output logic [N-1:0] cv_bcd_o,
    input  logic         cv_ready_i,
    input  logic         cv_done_i,
    input  logic [31:0]  cv_binary_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic [N-1:0]   bcd_q, bcd_d;
    logic [31:0]    result0_q, result0_d;
    logic [31:0]    result1_q, result1_d;
    logic           grant_sel;
    logic           take_req;
    logic           timeout_hit;
    logic           wait_exit;
    logic [31:0]    wait_value;

    // Both requesting: the port that was not served last wins.
    assign grant_sel = (req0_i && req1_i) ? ~last_grant_q : req1_i;
    assign take_req  = (state_q == IDLE) && cv_ready_i && (req0_i || req1_i);
    assign wait_exit = (state_q == WAIT) && (cv_done_i || timeout_hit);
    assign wait_value = cv_done_i ? cv_binary_i : 32'hFFFF_FFFF;

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CW'(1);
        end
        // A done arriving on the limit cycle wins over the timeout.
        if (wait_exit) begin
            err_d = ~cv_done_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cv_done_i || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        bcd_d        = bcd_q;
        result0_d    = result0_q;
        result1_d    = result1_q;
        if (take_req) begin
            owner_d = grant_sel;
            bcd_d   = grant_sel ? bcd1_i : bcd0_i;
        end
        if (wait_exit) begin
            if (owner_q) result1_d = wait_value;
            else         result0_d = wait_value;
        end
        if (state_q == RESP) begin
            last_grant_d = owner_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bcd_q        <= '0;
            result0_q    <= '0;
            result1_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            bcd_q        <= bcd_d;
            result0_q    <= result0_d;
            result1_q    <= result1_d;
        end
    end

    // Moore outputs decoded from registered state and owner
    always_comb begin
        busy_o     = (state_q != IDLE);
        cv_start_o = (state_q == ISSUE);
        cv_bcd_o   = bcd_q;
        ack0_o     = (state_q == ISSUE) && !owner_q;
        ack1_o     = (state_q == ISSUE) &&  owner_q;
        done0_o    = (state_q == RESP)  && !owner_q;
        done1_o    = (state_q == RESP)  &&  owner_q;
        result0_o  = result0_q;
        result1_o  = result1_q;
`ifdef BCD_ARB_TIMEOUT_EN
        err_o      = (state_q == RESP) && err_q;
`else
        err_o      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter with a behavioural 32-iteration converter model.
// Timeout scenario runs only when BCD_ARB_TIMEOUT_EN is defined.
module tb_bcd_conv_arbiter;

    localparam int N          = 8;
    localparam int TB_TIMEOUT = 64;
    localparam int LAT        = 34;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         req0_i, req1_i;
    logic [N-1:0] bcd0_i, bcd1_i;
    logic         ack0_o, ack1_o, done0_o, done1_o;
    logic [31:0]  result0_o, result1_o;
    logic         busy_o, err_o, cv_start_o;
    logic [N-1:0] cv_bcd_o;
    logic         cv_ready_i, cv_done_i;
    logic [31:0]  cv_binary_i;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  hold_ready_low = 1'b0;
    bit  force_no_done  = 1'b0;
    bit  inject_done    = 1'b0;

    // Scoreboard: expected results per port, plus the model's view of arbitration.
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    logic [31:0] res_m[2];
    int          last_grant_m = 1;

    bcd_conv_arbiter #(.N(N), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req0_i(req0_i), .bcd0_i(bcd0_i), .ack0_o(ack0_o), .done0_o(done0_o), .result0_o(result0_o),
        .req1_i(req1_i), .bcd1_i(bcd1_i), .ack1_o(ack1_o), .done1_o(done1_o), .result1_o(result1_o),
        .busy_o(busy_o), .err_o(err_o),
        .cv_start_o(cv_start_o), .cv_bcd_o(cv_bcd_o),
        .cv_ready_i(cv_ready_i), .cv_done_i(cv_done_i), .cv_binary_i(cv_binary_i)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] bcd_value(input logic [N-1:0] b);
        int v = 0;
        for (int i = N/4 - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return 32'(v);
    endfunction

    function automatic logic [N-1:0] rand_bcd();
        logic [N-1:0] b;
        for (int i = 0; i < N/4; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
        return b;
    endfunction

    function automatic int predict(input bit r0, input bit r1);
        if (r0 && r1) return (last_grant_m == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input int port, input logic [31:0] v);
        if (port == 1) exp1_q.push_back(v);
        else           exp0_q.push_back(v);
    endtask

    // ---------------- converter model: done 33 cycles after start is seen ----------------
    initial begin
        int           cnt;
        bit           cbusy;
        logic [N-1:0] lat;
        cnt = 0; cbusy = 0; lat = '0;
        cv_ready_i = 1'b1; cv_done_i = 1'b0; cv_binary_i = '0;
        forever begin
            @(negedge clk);
            if (cbusy) begin
                cnt++;
                if (cnt == 33) cbusy = 0;
            end else if (cv_start_o && cv_ready_i) begin
                cbusy = 1; cnt = 0; lat = cv_bcd_o;
            end
            @(posedge clk);
            #1;
            if (reset_i) begin cbusy = 0; cnt = 0; end
            cv_done_i   = (cbusy && cnt == 32 && !force_no_done) || inject_done;
            cv_ready_i  = !cbusy && !hold_ready_low;
            cv_binary_i = (cbusy && cnt == 32) ? bcd_value(lat) : $urandom;
        end
    end

    // ---------------- driver / monitor tasks ----------------
    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_o) return;
        end
        check("idle_timeout", 32'(busy_o), 0);
    endtask

    task automatic wait_ack(output int port, output int waited);
        port = -1; waited = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack0_o || ack1_o) begin
                port = ack1_o ? 1 : 0;
                waited = i;
                check("ack_onehot", 32'(ack0_o & ack1_o), 0);
                check("cv_start_at_ack", 32'(cv_start_o), 1);
                return;
            end
        end
        check("ack_timeout", 32'(ack0_o | ack1_o), 1);
    endtask

    task automatic wait_done(input int port, input int lat, input bit exp_err);
        bit          stray = 0;
        bit          idle_seen = 0;
        logic        mine, other;
        logic [31:0] expv;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            mine  = (port == 1) ? done1_o : done0_o;
            other = (port == 1) ? done0_o : done1_o;
            if (!busy_o) idle_seen = 1;
            if (other) stray = 1;
            if (mine) begin
                check("done_latency", 32'(i), 32'(lat));
                check("busy_during_op", 32'(idle_seen), 0);
                check("other_done_quiet", 32'(stray), 0);
                check("err_flag", 32'(err_o), 32'(exp_err));
                if (port == 1) begin
                    expv = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hDEAD_BEEF;
                    check("result1", result1_o, expv);
                    check("result0_hold", result0_o, res_m[0]);
                end else begin
                    expv = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hDEAD_BEEF;
                    check("result0", result0_o, expv);
                    check("result1_hold", result1_o, res_m[1]);
                end
                res_m[port]  = expv;
                last_grant_m = port;
                return;
            end
        end
        check("done_timeout", 32'(port == 1 ? done1_o : done0_o), 1);
    endtask

    task automatic run_single(input bit r0, input bit r1, input logic [N-1:0] b0, input logic [N-1:0] b1);
        int           port, waited, exp_port;
        logic [N-1:0] wb;
        wait_idle();
        req0_i = r0; req1_i = r1; bcd0_i = b0; bcd1_i = b1;
        exp_port = predict(r0, r1);
        wb = (exp_port == 1) ? b1 : b0;
        push_exp(exp_port, bcd_value(wb));
        wait_ack(port, waited);
        check("grant_port", 32'(port), 32'(exp_port));
        check("req_to_ack", 32'(waited), 1);
        check("cv_bcd", 32'(cv_bcd_o), 32'(wb));
        req0_i = 1'b0; req1_i = 1'b0;
        bcd0_i = rand_bcd(); bcd1_i = rand_bcd();
        wait_done(exp_port, LAT, 1'b0);
    endtask

    task automatic run_held(input int ops, input logic [N-1:0] b0, input logic [N-1:0] b1);
        int port, waited, exp_port;
        wait_idle();
        req0_i = 1'b1; req1_i = 1'b1; bcd0_i = b0; bcd1_i = b1;
        for (int k = 0; k < ops; k++) begin
            exp_port = predict(1'b1, 1'b1);
            push_exp(exp_port, bcd_value(exp_port == 1 ? b1 : b0));
            wait_ack(port, waited);
            check("held_grant", 32'(port), 32'(exp_port));
            check(k == 0 ? "held_first_ack" : "held_turnaround", 32'(waited), k == 0 ? 32'd1 : 32'd2);
            wait_done(exp_port, LAT, 1'b0);
        end
        req0_i = 1'b0; req1_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 32'({busy_o, ack0_o, ack1_o, done0_o, done1_o, err_o, cv_start_o}), 0);
        check({tag, "_result0"}, result0_o, 0);
        check({tag, "_result1"}, result1_o, 0);
        check({tag, "_cv_bcd"}, 32'(cv_bcd_o), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int           port, waited;
        bit           quiet;
        logic [N-1:0] b;
        res_m[0] = '0; res_m[1] = '0;
        reset_i = 1'b1;
        req0_i = 1'b0; req1_i = 1'b0; bcd0_i = '0; bcd1_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_i = 1'b0;

        // Single request, port 1 untouched
        run_single(1'b1, 1'b0, 8'h42, 8'h00);
        check("single_port1_result", result1_o, 0);

        // Mid-operation reset; a later op must still work from a clean state
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        res_m[0] = '0; res_m[1] = '0; last_grant_m = 1;

        // Simultaneous requests from reset, then fairness over four operations
        run_held(2, 8'h99, 8'h17);
        run_held(4, rand_bcd(), rand_bcd());

        // Withdraw and stall while the converter is not ready
        wait_idle();
        hold_ready_low = 1'b1;
        repeat (2) @(negedge clk);
        req1_i = 1'b1; bcd1_i = rand_bcd();
        @(negedge clk);
        req1_i = 1'b0;
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        quiet = 0;
        repeat (5) begin
            @(negedge clk);
            quiet |= busy_o | ack0_o | ack1_o | done0_o | done1_o;
        end
        check("stall_quiet", 32'(quiet), 0);
        check("stall_result0", result0_o, res_m[0]);
        check("stall_result1", result1_o, res_m[1]);
        b = rand_bcd();
        req0_i = 1'b1; bcd0_i = b;
        repeat (3) begin
            @(negedge clk);
            quiet |= busy_o | ack0_o | ack1_o;
        end
        check("stall_hold", 32'(quiet), 0);
        push_exp(0, bcd_value(b));
        hold_ready_low = 1'b0;
        wait_ack(port, waited);
        check("stall_grant", 32'(port), 0);
        check("stall_release_ack", 32'(waited), 2);
        req0_i = 1'b0;
        wait_done(0, LAT, 1'b0);

        // Reset ten cycles into WAIT
        wait_idle();
        b = rand_bcd();
        req0_i = 1'b1; bcd0_i = b;
        push_exp(0, bcd_value(b));
        wait_ack(port, waited);
        check("midrst_grant", 32'(port), 0);
        req0_i = 1'b0;
        repeat (10) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check_all_zero("midrst");
        exp0_q.delete(); exp1_q.delete();
        @(negedge clk);
        check_all_zero("midrst_hold");
        reset_i = 1'b0;
        res_m[0] = '0; res_m[1] = '0; last_grant_m = 1;
        run_single(1'b1, 1'b0, 8'h05, rand_bcd());
        check("post_reset_result0", result0_o, 32'h5);

`ifdef BCD_ARB_TIMEOUT_EN
        // Converter never finishes: error result and err_o with done0
        wait_idle();
        force_no_done = 1'b1;
        req0_i = 1'b1; bcd0_i = rand_bcd();
        push_exp(0, 32'hFFFF_FFFF);
        wait_ack(port, waited);
        req0_i = 1'b0;
        wait_done(0, TB_TIMEOUT + 1, 1'b1);
        force_no_done = 1'b0;
`endif

        // Randomized traffic
        for (int k = 0; k < 16; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            run_single(pat[0], pat[1], rand_bcd(), rand_bcd());
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
